// File: rtl/sad_pkg.sv
// Shared types and default geometry for the binary template-matching SAD controller.
package sad_pkg;

  localparam int TPL_W_DEF   = 4000;
  localparam int LOAD_W_DEF  = 32;
  localparam int CHUNK_W_DEF = 200;
  localparam int COL_W_DEF   = 10;
  localparam int ROW_W_DEF   = 10;

  localparam int NWORDS = TPL_W_DEF / LOAD_W_DEF;
  localparam int NCHUNK = TPL_W_DEF / CHUNK_W_DEF;
  localparam int SW     = $clog2(TPL_W_DEF + 1);

  localparam logic [SW-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    SCAN,
    CMP,
    REPORT
  } state_t;

  function automatic int score_width(input int tpl_w);
    return $clog2(tpl_w + 1);
  endfunction

endpackage

// File: rtl/sad_popcnt.sv
// Combinational popcount of one CHUNK_W slice as a balanced adder tree.
module sad_popcnt #(
  parameter int CHUNK_W = 200
) (
  input  logic [CHUNK_W-1:0]         chunk,
  output logic [$clog2(CHUNK_W+1)-1:0] count
);

  localparam int PC_W   = $clog2(CHUNK_W + 1);
  localparam int LEVELS = (CHUNK_W > 1) ? $clog2(CHUNK_W) : 1;
  localparam int LEAVES = 1 << LEVELS;

  genvar gl, gi;
  // Level 0 holds single bits padded to a power of two; each level halves the node count.
  for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
    localparam int N = LEAVES >> gl;
    logic [PC_W-1:0] sum [N];
    if (gl == 0) begin : g_leaves
      for (gi = 0; gi < N; gi++) begin : g_n
        if (gi < CHUNK_W) begin : g_bit
          assign sum[gi] = PC_W'(chunk[gi]);
        end else begin : g_pad
          assign sum[gi] = '0;
        end
      end
    end else begin : g_adds
      for (gi = 0; gi < N; gi++) begin : g_n
        assign sum[gi] = g_lvl[gl-1].sum[2*gi] + g_lvl[gl-1].sum[2*gi+1];
      end
    end
  end

  assign count = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/sad_match_ctrl.sv
// Template loader and serial-popcount minimum-score tracker with per-frame reporting.
// Define SAD_THRESH_EN to add the thresh input and hit/hit_count outputs.
module sad_match_ctrl
  import sad_pkg::*;
#(
  parameter int TPL_W   = TPL_W_DEF,
  parameter int LOAD_W  = LOAD_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int COL_W   = COL_W_DEF,
  parameter int ROW_W   = ROW_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ena,
  input  logic                             tpl_start,
  input  logic                             tpl_valid,
  input  logic [LOAD_W-1:0]                tpl_data,
  output logic                             tpl_we,
  output logic [$clog2(TPL_W/LOAD_W)-1:0]  tpl_addr,
  output logic [LOAD_W-1:0]                tpl_wdata,
  output logic                             tpl_loaded,
  input  logic [TPL_W-1:0]                 diff_in,
  input  logic                             win_valid,
  output logic                             win_ready,
  input  logic [COL_W-1:0]                 win_col,
  input  logic [ROW_W-1:0]                 win_row,
  input  logic                             frame_end,
  output logic                             busy,
  output logic                             result_valid,
  output logic [$clog2(TPL_W+1)-1:0]       best_score,
  output logic [COL_W-1:0]                 best_col,
  output logic [ROW_W-1:0]                 best_row
`ifdef SAD_THRESH_EN
  ,
  input  logic [$clog2(TPL_W+1)-1:0]       thresh,
  output logic                             hit,
  output logic [15:0]                      hit_count
`endif
);

  localparam int WORDS   = TPL_W / LOAD_W;
  localparam int CHUNKS  = TPL_W / CHUNK_W;
  localparam int SCORE_W = score_width(TPL_W);
  localparam int AW      = $clog2(WORDS);
  localparam int CNT_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PC_W    = $clog2(CHUNK_W + 1);

  state_t state_reg, state_next;

  logic [AW-1:0]      word_idx_reg;
  logic               tpl_loaded_reg;
  logic [CNT_W-1:0]   chunk_cnt_reg;
  logic [SCORE_W-1:0] acc_reg;
  logic [TPL_W-1:0]   shift_reg;
  logic [COL_W-1:0]   cur_col_reg;
  logic [ROW_W-1:0]   cur_row_reg;
  logic [SCORE_W-1:0] best_score_reg;
  logic [COL_W-1:0]   best_col_reg;
  logic [ROW_W-1:0]   best_row_reg;
  logic [SCORE_W-1:0] out_score_reg;
  logic [COL_W-1:0]   out_col_reg;
  logic [ROW_W-1:0]   out_row_reg;
  logic               frame_pending_reg;

  logic               accept;
  logic               last_beat;
  logic               last_chunk;
  logic               take;
  logic               to_report;
  logic [PC_W-1:0]    pc;
  logic [SCORE_W-1:0] cand_score;
  logic [COL_W-1:0]   cand_col;
  logic [ROW_W-1:0]   cand_row;

  sad_popcnt #(.CHUNK_W(CHUNK_W)) u_popcnt (
    .chunk (shift_reg[TPL_W-1 -: CHUNK_W]),
    .count (pc)
  );

  assign last_beat  = (word_idx_reg == AW'(WORDS - 1));
  assign last_chunk = (chunk_cnt_reg == CNT_W'(CHUNKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    tpl_we       = 1'b0;
    win_ready    = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    if (ena) begin
      case (state_reg)
        IDLE: if (tpl_start) state_next = LOAD;
        LOAD: begin
          if (!tpl_start && tpl_valid) begin
            tpl_we = 1'b1;
            if (last_beat) state_next = READY;
          end
        end
        READY: begin
          win_ready = 1'b1;
          accept    = win_valid;
          if (win_valid)      state_next = SCAN;
          else if (tpl_start) state_next = LOAD;
          else if (frame_end) state_next = REPORT;
        end
        SCAN: if (last_chunk) state_next = CMP;
        CMP: begin
          if (frame_pending_reg || frame_end) state_next = REPORT;
          else                                state_next = READY;
        end
        REPORT: begin
          result_valid = 1'b1;
          state_next   = READY;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Post-compare best; also what a report presents when entered straight from CMP.
  always_comb begin
    take       = (state_reg == CMP) && (acc_reg < best_score_reg);
    cand_score = take ? acc_reg     : best_score_reg;
    cand_col   = take ? cur_col_reg : best_col_reg;
    cand_row   = take ? cur_row_reg : best_row_reg;
  end

  assign to_report = (state_reg != REPORT) && (state_next == REPORT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_idx_reg      <= '0;
      tpl_loaded_reg    <= 1'b0;
      chunk_cnt_reg     <= '0;
      acc_reg           <= '0;
      shift_reg         <= '0;
      cur_col_reg       <= '0;
      cur_row_reg       <= '0;
      best_score_reg    <= '1;
      best_col_reg      <= '0;
      best_row_reg      <= '0;
      out_score_reg     <= '0;
      out_col_reg       <= '0;
      out_row_reg       <= '0;
      frame_pending_reg <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        LOAD: begin
          if (tpl_start) begin
            word_idx_reg <= '0;
          end else if (tpl_valid) begin
            if (last_beat) begin
              word_idx_reg   <= '0;
              tpl_loaded_reg <= 1'b1;
            end else begin
              word_idx_reg <= word_idx_reg + 1'b1;
            end
          end
        end
        READY: begin
          if (accept) begin
            shift_reg     <= diff_in;
            cur_col_reg   <= win_col;
            cur_row_reg   <= win_row;
            acc_reg       <= '0;
            chunk_cnt_reg <= '0;
            if (frame_end) frame_pending_reg <= 1'b1;
          end else if (tpl_start) begin
            tpl_loaded_reg <= 1'b0;
            word_idx_reg   <= '0;
          end
        end
        SCAN: begin
          acc_reg       <= acc_reg + SCORE_W'(pc);
          shift_reg     <= shift_reg << CHUNK_W;
          chunk_cnt_reg <= chunk_cnt_reg + 1'b1;
          if (frame_end) frame_pending_reg <= 1'b1;
        end
        CMP: begin
          best_score_reg <= cand_score;
          best_col_reg   <= cand_col;
          best_row_reg   <= cand_row;
        end
        REPORT: begin
          best_score_reg    <= '1;
          best_col_reg      <= '0;
          best_row_reg      <= '0;
          frame_pending_reg <= 1'b0;
        end
        default: ;
      endcase
      if (to_report) begin
        out_score_reg <= cand_score;
        out_col_reg   <= cand_col;
        out_row_reg   <= cand_row;
      end
    end
  end

  assign tpl_addr   = word_idx_reg;
  assign tpl_wdata  = tpl_we ? tpl_data : '0;
  assign tpl_loaded = tpl_loaded_reg;
  assign busy       = (state_reg != IDLE) && (state_reg != READY);
  assign best_score = out_score_reg;
  assign best_col   = out_col_reg;
  assign best_row   = out_row_reg;

`ifdef SAD_THRESH_EN
  logic [15:0] hit_count_reg;

  assign hit = ena && (state_reg == CMP) && (acc_reg <= thresh);

  // The count is presented during REPORT and cleared on leaving it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_reg <= '0;
    end else if (ena) begin
      if (state_reg == REPORT)                  hit_count_reg <= '0;
      else if (hit && (hit_count_reg != '1))    hit_count_reg <= hit_count_reg + 1'b1;
    end
  end

  assign hit_count = hit_count_reg;
`endif

endmodule

// File: tb/tb_sad_match_ctrl.sv
// Self-checking bench for sad_match_ctrl: directed scenarios plus randomized frames vs a min-popcount model.
module tb_sad_match_ctrl;

  localparam int TPL_W  = 4000;
  localparam int LOAD_W = 32;
  localparam int NWORDS = 125;
  localparam int SW     = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic              tpl_start;
  logic              tpl_valid;
  logic [LOAD_W-1:0] tpl_data;
  logic              tpl_we;
  logic [6:0]        tpl_addr;
  logic [LOAD_W-1:0] tpl_wdata;
  logic              tpl_loaded;
  logic [TPL_W-1:0]  diff_in;
  logic              win_valid;
  logic              win_ready;
  logic [9:0]        win_col;
  logic [9:0]        win_row;
  logic              frame_end;
  logic              busy;
  logic              result_valid;
  logic [SW-1:0]     best_score;
  logic [9:0]        best_col;
  logic [9:0]        best_row;
`ifdef SAD_THRESH_EN
  logic [SW-1:0]     thresh = '0;
  logic              hit;
  logic [15:0]       hit_count;
`endif

  sad_match_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena),
    .tpl_start(tpl_start), .tpl_valid(tpl_valid), .tpl_data(tpl_data),
    .tpl_we(tpl_we), .tpl_addr(tpl_addr), .tpl_wdata(tpl_wdata), .tpl_loaded(tpl_loaded),
    .diff_in(diff_in), .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row), .frame_end(frame_end),
    .busy(busy), .result_valid(result_valid),
    .best_score(best_score), .best_col(best_col), .best_row(best_row)
`ifdef SAD_THRESH_EN
    , .thresh(thresh), .hit(hit), .hit_count(hit_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Reference model: running minimum over the windows of the current frame, first wins on ties.
  typedef struct {
    int score;
    int col;
    int row;
  } res_t;

  res_t exp_q[$];
  int   m_best = 4095;
  int   m_col  = 0;
  int   m_row  = 0;

  always @(negedge clk) begin
    res_t e;
    int   pc;
    if (!rst) begin
      m_best = 4095; m_col = 0; m_row = 0;
      exp_q.delete();
    end else begin
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("best_score", best_score, e.score);
          chk("best_col", best_col, e.col);
          chk("best_row", best_row, e.row);
          $display("result: score=%0d col=%0d row=%0d", best_score, best_col, best_row);
        end
      end
      if (win_valid && win_ready) begin
        pc = $countones(diff_in);
        if (pc < m_best) begin
          m_best = pc; m_col = win_col; m_row = win_row;
        end
      end
      if (frame_end && ena) begin
        e.score = m_best; e.col = m_col; e.row = m_row;
        exp_q.push_back(e);
        m_best = 4095; m_col = 0; m_row = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_template(input bit seq, input bit gaps);
    logic [LOAD_W-1:0] w;
    int ng;
    ena = 1'b1;
    wait_idle();
    tpl_start = 1'b1;
    @(posedge clk); #1;
    tpl_start = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      ng = gaps ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < ng; g++) begin
        tpl_valid = 1'b0;
        @(negedge clk);
        chk("tpl_we_gap", tpl_we, 0);
        @(posedge clk); #1;
      end
      w = seq ? LOAD_W'(i) : LOAD_W'($urandom);
      tpl_valid = 1'b1;
      tpl_data  = w;
      @(negedge clk);
      chk("tpl_we", tpl_we, 1);
      chk("tpl_addr", tpl_addr, i);
      chk("tpl_wdata", tpl_wdata, w);
      if (i == 0) chk("tpl_loaded_during_load", tpl_loaded, 0);
      @(posedge clk); #1;
    end
    tpl_valid = 1'b0;
    @(negedge clk);
    chk("tpl_loaded", tpl_loaded, 1);
    chk("ready_after_load", win_ready, 1);
    chk("busy_after_load", busy, 0);
    $display("template loaded: %0d words", NWORDS);
    @(posedge clk); #1;
  endtask

  task automatic make_vec(input int k, output logic [TPL_W-1:0] v);
    v = '0;
    if (k < 0) begin
      for (int w = 0; w < TPL_W / 32; w++) v[w*32 +: 32] = $urandom;
    end else begin
      for (int i = 0; i < 100000 && $countones(v) < k; i++)
        v[$urandom_range(TPL_W - 1, 0)] = 1'b1;
    end
  endtask

  task automatic send_window(input logic [TPL_W-1:0] v, input int col, input int row,
                             input bit fe, input bit stall);
    bit done = 0;
    if (fe) begin
      ena = 1'b1;
      wait_idle();
    end
    diff_in = v; win_col = 10'(col); win_row = 10'(row);
    win_valid = 1'b1; frame_end = fe;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      done = win_valid && win_ready;
      @(posedge clk); #1;
      if (done) break;
      if (stall) ena = ($urandom_range(0, 3) != 0);
    end
    if (!done) chk("accept_timeout", 0, 1);
    $display("window: col=%0d row=%0d ones=%0d frame_end=%0d", col, row, $countones(v), fe);
    win_valid = 1'b0; frame_end = 1'b0; ena = 1'b1;
  endtask

  task automatic wait_result(output logic [SW-1:0] s, output logic [9:0] c, output logic [9:0] r);
    bit got = 0;
    s = '0; c = '0; r = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1; s = best_score; c = best_col; r = best_row;
        break;
      end
    end
    if (!got) chk("result_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic end_frame(output logic [SW-1:0] s, output logic [9:0] c, output logic [9:0] r);
    ena = 1'b1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    wait_result(s, c, r);
  endtask

  // Cycles spent busy after an accept; optionally drops ena for 10 cycles mid-scan.
  task automatic measure_busy(input bit stall, output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk); #1;
      ena = !(stall && n >= 5 && n < 15);
    end
    ena = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [TPL_W-1:0] v;
    logic [SW-1:0]    s;
    logic [9:0]       c, r;
    int               n, nwin, k, nres;
    bit               stall, coinc;

    rst = 1'b0; ena = 1'b1; tpl_start = 1'b0; tpl_valid = 1'b0; tpl_data = '0;
    diff_in = '0; win_valid = 1'b0; win_col = '0; win_row = '0; frame_end = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tpl_loaded", tpl_loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_best_score", best_score, 0);
    chk("rst_tpl_we", tpl_we, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    load_template(1, 0);

    // Zero-difference window wins over all-ones; both scans take NCHUNK+1 busy cycles.
    send_window('0, 3, 5, 0, 0);
    measure_busy(0, n);
    chk("latency_first", n, 21);
    v = '1;
    send_window(v, 7, 9, 0, 0);
    measure_busy(0, n);
    chk("latency_second", n, 21);
    end_frame(s, c, r);
    chk("t1_score", s, 0);
    chk("t1_col", c, 3);
    chk("t1_row", r, 5);

    // Equal scores: the earlier window is kept.
    make_vec(100, v);
    send_window(v, 1, 1, 0, 0);
    chk("result_held", best_score, 0);
    make_vec(100, v);
    send_window(v, 2, 2, 0, 0);
    end_frame(s, c, r);
    chk("tie_score", s, 100);
    chk("tie_col", c, 1);
    chk("tie_row", r, 1);

    // frame_end in the accept cycle, then an empty frame must show the reset best.
    make_vec(7, v);
    send_window(v, 4, 6, 1, 0);
    wait_result(s, c, r);
    chk("coinc_score", s, 7);
    chk("coinc_col", c, 4);
    end_frame(s, c, r);
    chk("empty_score", s, 4095);
    chk("empty_col", c, 0);
    chk("empty_row", r, 0);

    // Ten stalled cycles stretch the scan by exactly ten.
    make_vec(50, v);
    send_window(v, 8, 8, 0, 0);
    measure_busy(1, n);
    chk("latency_stall", n, 31);
    end_frame(s, c, r);
    chk("stall_score", s, 50);

    // Reloading mid-frame keeps the best so far.
    make_vec(30, v);
    send_window(v, 11, 12, 0, 0);
    load_template(0, 1);
    make_vec(40, v);
    send_window(v, 13, 14, 0, 0);
    end_frame(s, c, r);
    chk("reload_score", s, 30);
    chk("reload_col", c, 11);
    chk("reload_row", r, 12);

    for (int f = 0; f < 12; f++) begin
      nwin  = $urandom_range(0, 4);
      stall = 1'($urandom_range(0, 1));
      coinc = (nwin > 0) && ($urandom_range(0, 2) == 0);
      for (int w = 0; w < nwin; w++) begin
        k = ($urandom_range(0, 3) == 0) ? -1 : 10 * $urandom_range(0, 6);
        make_vec(k, v);
        if (w == 1 && $urandom_range(0, 4) == 0) load_template(0, 1);
        send_window(v, $urandom_range(0, 1023), $urandom_range(0, 1023),
                    coinc && (w == nwin - 1), stall);
      end
      if (coinc) wait_result(s, c, r);
      else       end_frame(s, c, r);
    end

    // Reset in the middle of a scan: back to IDLE, template gone, no report.
    make_vec(20, v);
    send_window(v, 1, 2, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_tpl_loaded", tpl_loaded, 0);
    chk("midrst_win_ready", win_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    nres = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) nres++;
    end
    chk("midrst_no_result", nres, 0);
    chk("midrst_idle", busy, 0);
    chk("midrst_still_unloaded", tpl_loaded, 0);
    @(posedge clk); #1;

    load_template(1, 1);
    make_vec(5, v);
    send_window(v, 21, 22, 0, 1);
    end_frame(s, c, r);
    chk("recover_score", s, 5);
    chk("recover_col", c, 21);

    chk("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
